inst_fetch_ctrl: RTL and testbench
==================================

Name: inst_fetch_ctrl

Overview:
- Instruction sequencer directly upstream of the instruction decoder.
- Holds a small programmable instruction memory and a program counter (PC) with hardware loop control.
- Presents one instruction per cycle as `inst_code_o`, qualified by `inst_valid_o`; the decoder uses `inst_valid_o` as its enable.
- Holds the current instruction while `stall_i` is high, e.g. when an item-memory (IM) FIFO is empty or the associative memory (AM) is busy.

Parameters:
- InstWidth, 32, instruction word width; must match the decoder.
- NumInst, 64, instruction memory depth in words.
- LoopCntWidth, 16, width of the loop iteration counter.
- InstAddrWidth, $clog2(NumInst), PC and address width (derived; do not override).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- cfg_wr_en_i  in  1  instruction memory write strobe; honoured in IDLE only.
- cfg_wr_addr_i  in  InstAddrWidth  instruction memory write address.
- cfg_wr_data_i  in  InstWidth  instruction memory write data.
- loop_end_addr_i  in  InstAddrWidth  last PC of the program body.
- loop_count_i  in  LoopCntWidth  number of passes over the body; 0 is treated as 1.
- start_i  in  1  start execution from PC 0; honoured in IDLE only.
- clr_i  in  1  synchronous abort back to IDLE.
- stall_i  in  1  hold the current PC and instruction.
- inst_code_o  out  InstWidth  instruction at the current PC; all zeros when not running.
- inst_valid_o  out  1  instruction valid; high in RUN.
- inst_pc_o  out  InstAddrWidth  current PC.
- busy_o  out  1  high in RUN.
- done_o  out  1  one-cycle pulse when the program completes.

Behaviour:
- Reset values:
  - FSM in IDLE; PC = 0; iteration counter = 0; latched configuration = 0.
  - All outputs 0.
  - Instruction memory contents are not reset; they are undefined until written.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `cfg_wr_en_i` writes `cfg_wr_data_i` to memory[`cfg_wr_addr_i`] at the clock edge.
  - `start_i` latches `loop_end_addr_i` and max(`loop_count_i`, 1), clears PC and iteration counter, and moves to RUN.
  - A write and a start in the same cycle: both take effect, and the written word is visible at the first RUN fetch.
- RUN:
  - Memory read is combinational: `inst_code_o` = mem[PC]; `inst_valid_o` = 1; `busy_o` = 1.
  - `stall_i` = 1: PC, counter and outputs hold.
  - `stall_i` = 0 and PC != latched end address: PC increments by 1.
  - `stall_i` = 0 and PC == end address, iteration counter < count-1: PC returns to 0 and the counter increments. Zero-bubble wrap: the instruction at address 0 is valid on the next cycle.
  - `stall_i` = 0 and PC == end address, iteration counter == count-1: go to DONE.
  - The PC never exceeds NumInst-1. If the end address equals NumInst-1, the PC wraps with the loop, not with arithmetic overflow.
- DONE:
  - Lasts one cycle: `done_o` = 1, `inst_valid_o` = 0, `inst_code_o` = 0.
  - Then IDLE with PC = 0.
- clr_i:
  - Highest priority in any state: next state IDLE, PC and counter = 0.
  - No `done_o` pulse; memory contents are preserved.
  - `clr_i` together with `start_i` in IDLE: `clr_i` wins.
- Writes outside IDLE are ignored. `start_i` outside IDLE is ignored.
- Latency:
  - `start_i` at edge N gives `inst_valid_o` high during cycle N+1.
  - The last instruction accepted at edge M gives `done_o` during cycle M+1.
- Reset asserted mid-RUN: all outputs zero immediately (asynchronous). After release the FSM is in IDLE.

Decomposition:
- hypercorex_inst_pkg gets:
  - fetch FSM state enum typedef (IDLE/RUN/DONE);
  - constant for the default instruction memory depth.
- One sub-module, inst_mem: NumInst x InstWidth flop array with one synchronous write port and one combinational read port, no reset on the data.
- PC, loop counter and FSM stay in inst_fetch_ctrl.

Test Plan:
- Load 4 words 0x11,0x22,0x33,0x44 at addresses 0..3; end=3, count=1; start -> `inst_code_o` 0x11,0x22,0x33,0x44 on 4 consecutive valid cycles, then `done_o` pulses once and `busy_o` falls.
- Same program with end=1, count=3 -> sequence 0x11,0x22 ×3 with no bubbles, `done_o` after the sixth valid cycle; `loop_count_i`=0 runs exactly one pass.
- `stall_i` high for 3 cycles at PC=2 -> `inst_pc_o` stays 2 and `inst_code_o` stays 0x33 for 4 cycles total, then PC advances to 3.
- `clr_i` at PC=2 of iteration 1 -> IDLE next cycle, `inst_valid_o`=0, no `done_o`; a restart runs from PC 0 with memory intact.
- Write to address 0 during RUN -> ignored, a later readback still returns 0x11; `start_i` during RUN is ignored; a write plus start in the same IDLE cycle executes the new word first.
- Assert `rst_ni` mid-RUN -> outputs 0 asynchronously, FSM in IDLE; end=NumInst-1 with count=2 -> PC wraps 63→0 once, then `done_o` fires.

Source files
------------

// File: rtl/hypercorex_inst_pkg.sv
// Shared types and default sizing for the instruction fetch controller.
package hypercorex_inst_pkg;

    localparam int unsigned DefaultNumInst      = 64;
    localparam int unsigned DefaultInstWidth    = 32;
    localparam int unsigned DefaultLoopCntWidth = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/inst_fetch_ctrl_if.sv
// Configuration, control and instruction-output bundle of the fetch controller.
// master: the side that programs/controls the sequencer; slave: the sequencer.
interface inst_fetch_ctrl_if
    import hypercorex_inst_pkg::*;
#(
    parameter int unsigned InstWidth     = DefaultInstWidth,
    parameter int unsigned NumInst       = DefaultNumInst,
    parameter int unsigned LoopCntWidth  = DefaultLoopCntWidth,
    parameter int unsigned InstAddrWidth = $clog2(NumInst)
);

    logic                     cfg_wr_en_i;
    logic [InstAddrWidth-1:0] cfg_wr_addr_i;
    logic [InstWidth-1:0]     cfg_wr_data_i;
    logic [InstAddrWidth-1:0] loop_end_addr_i;
    logic [LoopCntWidth-1:0]  loop_count_i;
    logic                     start_i;
    logic                     clr_i;
    logic                     stall_i;
    logic [InstWidth-1:0]     inst_code_o;
    logic                     inst_valid_o;
    logic [InstAddrWidth-1:0] inst_pc_o;
    logic                     busy_o;
    logic                     done_o;

    modport master (
        output cfg_wr_en_i, cfg_wr_addr_i, cfg_wr_data_i,
        output loop_end_addr_i, loop_count_i, start_i, clr_i, stall_i,
        input  inst_code_o, inst_valid_o, inst_pc_o, busy_o, done_o
    );

    modport slave (
        input  cfg_wr_en_i, cfg_wr_addr_i, cfg_wr_data_i,
        input  loop_end_addr_i, loop_count_i, start_i, clr_i, stall_i,
        output inst_code_o, inst_valid_o, inst_pc_o, busy_o, done_o
    );

endinterface

// File: rtl/inst_fetch_ctrl_inst_mem.sv
// Instruction store: flop array, one synchronous write port, one
// combinational read port. Data is deliberately not reset.
module inst_mem #(
    parameter int unsigned InstWidth     = 32,
    parameter int unsigned NumInst       = 64,
    parameter int unsigned InstAddrWidth = $clog2(NumInst)
) (
    input  logic                     i_clk,
    input  logic                     i_wr_en,
    input  logic [InstAddrWidth-1:0] i_wr_addr,
    input  logic [InstWidth-1:0]     i_wr_data,
    input  logic [InstAddrWidth-1:0] i_rd_addr,
    output logic [InstWidth-1:0]     o_rd_data
);

    logic [InstWidth-1:0] r_mem [NumInst];

    // Write the addressed word on the clock edge when enabled.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction sequencer feeding the decoder: program memory, PC and
// hardware loop counter.
//
//  state   | meaning
//  --------+--------------------------------------------------------------
//  ST_IDLE | accepting memory writes and start; outputs quiet
//  ST_RUN  | presenting mem[PC] each cycle, advancing unless stalled
//  ST_DONE | single cycle done pulse, then back to ST_IDLE with PC = 0
module inst_fetch_ctrl
    import hypercorex_inst_pkg::*;
#(
    parameter int unsigned InstWidth    = DefaultInstWidth,
    parameter int unsigned NumInst      = DefaultNumInst,
    parameter int unsigned LoopCntWidth = DefaultLoopCntWidth
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    inst_fetch_ctrl_if.slave bus
);

    localparam int unsigned InstAddrWidth = $clog2(NumInst);
    localparam logic [InstAddrWidth-1:0] LastAddr = InstAddrWidth'(NumInst - 1);

    fetch_state_e             r_state;
    fetch_state_e             w_state_nxt;
    logic [InstAddrWidth-1:0] r_pc;
    logic [InstAddrWidth-1:0] w_pc_nxt;
    logic [InstAddrWidth-1:0] r_end_addr;
    logic [InstAddrWidth-1:0] w_end_nxt;
    logic [LoopCntWidth-1:0]  r_iter;
    logic [LoopCntWidth-1:0]  w_iter_nxt;
    logic [LoopCntWidth-1:0]  r_count;
    logic [LoopCntWidth-1:0]  w_count_nxt;
    logic [InstWidth-1:0]     w_rd_data;
    logic [InstWidth-1:0]     w_inst_code;
    logic                     w_wr_en;
    logic                     w_valid;
    logic                     w_busy;
    logic                     w_done;
    logic                     w_at_end;
    logic                     w_last_iter;

    inst_mem #(
        .InstWidth     (InstWidth),
        .NumInst       (NumInst),
        .InstAddrWidth (InstAddrWidth)
    ) u_inst_mem (
        .i_clk     (clk_i),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (bus.cfg_wr_addr_i),
        .i_wr_data (bus.cfg_wr_data_i),
        .i_rd_addr (r_pc),
        .o_rd_data (w_rd_data)
    );

    // The top address also ends the body so the PC can never run past the memory.
    assign w_at_end    = (r_pc == r_end_addr) || (r_pc == LastAddr);
    assign w_last_iter = (r_iter >= (r_count - LoopCntWidth'(1)));

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // PC, iteration counter and latched loop configuration.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pc       <= '0;
            r_iter     <= '0;
            r_end_addr <= '0;
            r_count    <= '0;
        end else begin
            r_pc       <= w_pc_nxt;
            r_iter     <= w_iter_nxt;
            r_end_addr <= w_end_nxt;
            r_count    <= w_count_nxt;
        end
    end

    // Next-state, datapath updates and outputs; clr_i overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_iter_nxt  = r_iter;
        w_end_nxt   = r_end_addr;
        w_count_nxt = r_count;
        w_wr_en     = 1'b0;
        w_inst_code = '0;
        w_valid     = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_wr_en = bus.cfg_wr_en_i;
                if (bus.start_i) begin
                    w_end_nxt   = bus.loop_end_addr_i;
                    w_count_nxt = (bus.loop_count_i == '0) ? LoopCntWidth'(1)
                                                          : bus.loop_count_i;
                    w_pc_nxt    = '0;
                    w_iter_nxt  = '0;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_inst_code = w_rd_data;
                w_valid     = 1'b1;
                w_busy      = 1'b1;
                if (!bus.stall_i) begin
                    if (!w_at_end) begin
                        w_pc_nxt = r_pc + InstAddrWidth'(1);
                    end else if (!w_last_iter) begin
                        w_pc_nxt   = '0;
                        w_iter_nxt = r_iter + LoopCntWidth'(1);
                    end else begin
                        w_pc_nxt    = '0;
                        w_iter_nxt  = '0;
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_done      = 1'b1;
                w_pc_nxt    = '0;
                w_iter_nxt  = '0;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_pc_nxt    = '0;
                w_iter_nxt  = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (bus.clr_i) begin
            w_state_nxt = ST_IDLE;
            w_pc_nxt    = '0;
            w_iter_nxt  = '0;
        end
    end

    assign bus.inst_code_o  = w_inst_code;
    assign bus.inst_valid_o = w_valid;
    assign bus.inst_pc_o    = r_pc;
    assign bus.busy_o       = w_busy;
    assign bus.done_o       = w_done;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Scoreboard bench for inst_fetch_ctrl: the stimulus side pushes the
// expected instruction stream of each program, a negedge monitor pops it.
module tb_inst_fetch_ctrl;
    import hypercorex_inst_pkg::*;

    localparam int IW = 32;
    localparam int NI = 64;
    localparam int LW = 16;
    localparam int AW = 6;

    typedef struct {
        bit            is_done;
        logic [AW-1:0] pc;
        logic [IW-1:0] code;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    inst_fetch_ctrl_if #(.InstWidth(IW), .NumInst(NI), .LoopCntWidth(LW)) bus ();

    inst_fetch_ctrl #(.InstWidth(IW), .NumInst(NI), .LoopCntWidth(LW)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    exp_t          q[$];
    logic [IW-1:0] model_mem [NI];
    int            checks = 0;
    int            failures = 0;
    int            done_seen = 0;
    bit            exp_done_next = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic fail_now(input string name, input int act, input int req);
        checks++;
        failures++;
        $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    endtask

    // Monitor: compare every presented instruction / done pulse against the queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (exp_done_next) begin
                chk("done_latency", {63'd0, bus.done_o}, 64'd1);
                exp_done_next = 1'b0;
            end
            if (bus.inst_valid_o) begin
                chk("busy_in_run", {63'd0, bus.busy_o}, 64'd1);
                if (q.size() == 0) begin
                    fail_now("unexpected_valid", int'(bus.inst_pc_o), -1);
                end else if (q[0].is_done) begin
                    fail_now("valid_instead_of_done", int'(bus.inst_pc_o), -1);
                end else begin
                    chk("inst_pc", 64'(bus.inst_pc_o), 64'(q[0].pc));
                    chk("inst_code", 64'(bus.inst_code_o), 64'(q[0].code));
                    if (!bus.stall_i) begin
                        void'(q.pop_front());
                        if (q.size() > 0 && q[0].is_done) exp_done_next = 1'b1;
                    end
                end
            end else begin
                chk("code_zero_not_run", 64'(bus.inst_code_o), 64'd0);
                chk("busy_not_run", {63'd0, bus.busy_o}, 64'd0);
            end
            if (bus.done_o) begin
                done_seen++;
                if (q.size() == 0 || !q[0].is_done) begin
                    fail_now("unexpected_done", 1, 0);
                end else begin
                    checks++;
                    void'(q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.cfg_wr_en_i   = 1'b0;
        bus.cfg_wr_addr_i = '0;
        bus.cfg_wr_data_i = '0;
        bus.start_i       = 1'b0;
        bus.clr_i         = 1'b0;
        bus.stall_i       = 1'b0;
    endtask

    task automatic flush();
        q.delete();
        exp_done_next = 1'b0;
    endtask

    task automatic write_word(input int addr, input logic [IW-1:0] data);
        bus.cfg_wr_en_i   = 1'b1;
        bus.cfg_wr_addr_i = AW'(addr);
        bus.cfg_wr_data_i = data;
        tick();
        bus.cfg_wr_en_i   = 1'b0;
        model_mem[addr]   = data;
    endtask

    // Reference: passes = max(count,1), each pass reads addresses 0..end.
    task automatic push_program(input int e, input int cnt);
        exp_t it;
        int passes = (cnt == 0) ? 1 : cnt;
        for (int p = 0; p < passes; p++) begin
            for (int a = 0; a <= e; a++) begin
                it.is_done = 1'b0;
                it.pc      = AW'(a);
                it.code    = model_mem[a];
                q.push_back(it);
            end
        end
        it.is_done = 1'b1;
        it.pc      = '0;
        it.code    = '0;
        q.push_back(it);
    endtask

    task automatic start_prog(input int e, input int cnt);
        push_program(e, cnt);
        bus.loop_end_addr_i = AW'(e);
        bus.loop_count_i    = LW'(cnt);
        bus.start_i         = 1'b1;
        tick();
        bus.start_i = 1'b0;
        chk("valid_after_start", {63'd0, bus.inst_valid_o}, 64'd1);
    endtask

    task automatic wait_done(input int prev, input int stall_pct, input bit disturb, input int budget);
        int n = 0;
        while (done_seen == prev && n < budget) begin
            bus.stall_i = ($urandom_range(99) < stall_pct);
            if (disturb) begin
                bus.cfg_wr_en_i   = ($urandom_range(7) == 0);
                bus.cfg_wr_addr_i = AW'($urandom_range(NI - 1));
                bus.cfg_wr_data_i = $urandom;
                bus.start_i       = ($urandom_range(7) == 0);
            end
            tick();
            n++;
        end
        idle_inputs();
        if (done_seen == prev) begin
            fail_now("timeout_waiting_done", n, budget);
            flush();
        end
        chk("queue_drained", 64'(q.size()), 64'd0);
    endtask

    task automatic run_prog(input int e, input int cnt, input int stall_pct, input bit disturb, input int budget);
        int prev = done_seen;
        start_prog(e, cnt);
        wait_done(prev, stall_pct, disturb, budget);
    endtask

    initial begin
        int prev;
        bus.loop_end_addr_i = '0;
        bus.loop_count_i    = '0;
        idle_inputs();
        repeat (2) tick();
        chk("rst_valid", {63'd0, bus.inst_valid_o}, 64'd0);
        chk("rst_busy", {63'd0, bus.busy_o}, 64'd0);
        chk("rst_done", {63'd0, bus.done_o}, 64'd0);
        chk("rst_code", 64'(bus.inst_code_o), 64'd0);
        chk("rst_pc", 64'(bus.inst_pc_o), 64'd0);
        rst_n = 1'b1;
        tick();

        for (int a = 0; a < NI; a++) write_word(a, $urandom);
        write_word(0, 32'h11);
        write_word(1, 32'h22);
        write_word(2, 32'h33);
        write_word(3, 32'h44);

        // Straight-line program, looped body, zero count.
        run_prog(3, 1, 0, 1'b0, 50);
        run_prog(1, 3, 0, 1'b0, 50);
        run_prog(1, 0, 0, 1'b0, 50);

        // Stall at PC=2 for three cycles.
        prev = done_seen;
        start_prog(3, 1);
        tick();
        tick();
        chk("pc_before_stall", 64'(bus.inst_pc_o), 64'd2);
        bus.stall_i = 1'b1;
        repeat (3) tick();
        bus.stall_i = 1'b0;
        tick();
        chk("pc_after_stall", 64'(bus.inst_pc_o), 64'd3);
        wait_done(prev, 0, 1'b0, 20);

        // Abort at PC=2 of the second pass, then restart.
        start_prog(3, 3);
        repeat (6) tick();
        chk("pc_before_clr", 64'(bus.inst_pc_o), 64'd2);
        bus.clr_i = 1'b1;
        tick();
        bus.clr_i = 1'b0;
        flush();
        chk("clr_valid", {63'd0, bus.inst_valid_o}, 64'd0);
        chk("clr_busy", {63'd0, bus.busy_o}, 64'd0);
        repeat (4) tick();
        run_prog(3, 1, 0, 1'b0, 50);

        // Write and start during RUN are ignored.
        prev = done_seen;
        start_prog(3, 1);
        bus.cfg_wr_en_i   = 1'b1;
        bus.cfg_wr_addr_i = '0;
        bus.cfg_wr_data_i = 32'hDEAD_BEEF;
        bus.start_i       = 1'b1;
        tick();
        idle_inputs();
        wait_done(prev, 0, 1'b0, 20);
        run_prog(0, 1, 0, 1'b0, 20);

        // Write plus start in the same IDLE cycle: new word fetched first.
        prev = done_seen;
        model_mem[0]      = 32'h0000_00AA;
        bus.cfg_wr_en_i   = 1'b1;
        bus.cfg_wr_addr_i = '0;
        bus.cfg_wr_data_i = 32'h0000_00AA;
        start_prog(3, 1);
        bus.cfg_wr_en_i = 1'b0;
        wait_done(prev, 0, 1'b0, 20);
        write_word(0, 32'h11);

        // clr beats start in IDLE.
        bus.clr_i   = 1'b1;
        bus.start_i = 1'b1;
        tick();
        idle_inputs();
        chk("clr_start_busy", {63'd0, bus.busy_o}, 64'd0);
        chk("clr_start_valid", {63'd0, bus.inst_valid_o}, 64'd0);

        // Asynchronous reset mid-RUN.
        start_prog(3, 3);
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        flush();
        chk("arst_valid", {63'd0, bus.inst_valid_o}, 64'd0);
        chk("arst_busy", {63'd0, bus.busy_o}, 64'd0);
        chk("arst_done", {63'd0, bus.done_o}, 64'd0);
        chk("arst_code", 64'(bus.inst_code_o), 64'd0);
        chk("arst_pc", 64'(bus.inst_pc_o), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_idle", {63'd0, bus.inst_valid_o}, 64'd0);
        run_prog(3, 1, 0, 1'b0, 50);

        // Full-depth body, PC wraps from the last address.
        run_prog(NI - 1, 2, 20, 1'b0, 400);

        // Randomized programs with stalls and ignored RUN-time disturbances.
        for (int r = 0; r < 20; r++) begin
            int nw = $urandom_range(3);
            for (int w = 0; w < nw; w++) write_word($urandom_range(15), $urandom);
            run_prog($urandom_range(15), $urandom_range(3), 30, 1'b1, 400);
        end

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
